// File: rtl/dual_clock_fifo_af_ae_ram.sv
// fifo_ram: simple dual-port storage array for the FIFO.
//   clk     - single clock, both ports act on its rising edge
//   wr_en   - write strobe; wr_data is stored at wr_addr
//   wr_addr - write index
//   wr_data - write data
//   rd_en   - read strobe; rd_data loads mem[rd_addr] on the edge
//   rd_addr - read index
//   rd_data - registered read data, holds its value while rd_en is low
// The array and the read register carry no reset; the owner decides
// what the output shows before the first read.
module fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // The read register only moves on a read strobe, so the last value
  // stays visible between reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dual_clock_fifo_af_ae.sv
// dual_clock_fifo_af_ae: single-clock FIFO with programmable almost-full
// and almost-empty flags.
//   clk            - clock, all state changes on its rising edge
//   rst_async_la_i - asynchronous active-low reset (pointers, output)
//   Write_enable_i - write request, taken only when not full
//   Read_enable__i - read request, taken only when not empty
//   differenceAF_i - almost-full distance below full, in words
//   differenceAE_i - almost-empty distance above empty, in words
//   data_input___i - write data
//   data_output__o - read data, valid one cycle after an accepted read
//   Empty_Indica_o / Full_Indicat_o / Almost_Full__o / Almost_Empty_o
//                  - status flags derived from the registered pointers
module dual_clock_fifo_af_ae #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_async_la_i,
  input  logic                  Write_enable_i,
  input  logic                  Read_enable__i,
  input  logic [ADDR_WIDTH-1:0] differenceAF_i,
  input  logic [ADDR_WIDTH-1:0] differenceAE_i,
  input  logic [DATA_WIDTH-1:0] data_input___i,
  output logic [DATA_WIDTH-1:0] data_output__o,
  output logic                  Empty_Indica_o,
  output logic                  Full_Indicat_o,
  output logic                  Almost_Full__o,
  output logic                  Almost_Empty_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // Pointers carry one extra wrap bit, so their modular difference is the
  // occupancy 0..DEPTH with no ambiguity between full and empty. All flags
  // come from the registered pointers only.
  always_comb begin
    count          = wptr_q - rptr_q;
    Empty_Indica_o = (count == '0);
    Full_Indicat_o = (count == DEPTH_P);
    Almost_Full__o = (count >= (DEPTH_P - {1'b0, differenceAF_i}));
    Almost_Empty_o = (count <= {1'b0, differenceAE_i});
  end

  // Requests are qualified by the flags as they stood before the edge, so
  // a read in the same cycle never frees room for a write while full, and
  // a write never makes data readable while empty.
  always_comb begin
    wr_accept   = Write_enable_i && !Full_Indicat_o;
    rd_accept   = Read_enable__i && !Empty_Indica_o;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    if (wr_accept) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rptr_d      = rptr_q + PTR_ONE;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wptr_q[ADDR_WIDTH-1:0]),
    .wr_data (data_input___i),
    .rd_en   (rd_accept),
    .rd_addr (rptr_q[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  // The RAM read register has no reset; out_valid_q is cleared
  // asynchronously so the output reads zero from reset until the first
  // accepted read, then simply follows the held RAM read register.
  assign data_output__o = out_valid_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_dual_clock_fifo_af_ae.sv
// tb_dual_clock_fifo_af_ae: directed self-checking bench for the FIFO with
// DATA_WIDTH=12, ADDR_WIDTH=3 and both almost thresholds set to 2.
module tb_dual_clock_fifo_af_ae;

  localparam int DW = 12;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic          re;
  logic [AW-1:0] daf;
  logic [AW-1:0] dae;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic          afull;
  logic          aempty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_clock_fifo_af_ae #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .rst_async_la_i (rst_n),
    .Write_enable_i (we),
    .Read_enable__i (re),
    .differenceAF_i (daf),
    .differenceAE_i (dae),
    .data_input___i (din),
    .data_output__o (dout),
    .Empty_Indica_o (empty),
    .Full_Indicat_o (full),
    .Almost_Full__o (afull),
    .Almost_Empty_o (aempty)
  );

  // One comparison: counts it, and on a miss counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic e, input logic f,
                            input logic a_f, input logic a_e);
    checkOutput({tag, ".empty"}, {31'd0, empty}, {31'd0, e});
    checkOutput({tag, ".full"}, {31'd0, full}, {31'd0, f});
    checkOutput({tag, ".afull"}, {31'd0, afull}, {31'd0, a_f});
    checkOutput({tag, ".aempty"}, {31'd0, aempty}, {31'd0, a_e});
  endtask

  // Drive one cycle of requests, then leave the bench 1 time unit past the
  // rising edge so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d);
    we  = w;
    re  = r;
    din = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b1;
    we    = 1'b0;
    re    = 1'b0;
    din   = '0;
    daf   = 3'd2;
    dae   = 3'd2;

    // Reset takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkFlags("rst_async", 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_async.dout", {20'd0, dout}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    checkFlags("rst_release", 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_release.dout", {20'd0, dout}, 32'h0);

    // Fill: count k after write k; AE clears at 3, AF sets at 6, full at 8.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, DW'(k));
      checkFlags($sformatf("fill%0d", k), 1'b0, (k == 8), (k >= 6), (k <= 2));
    end

    // Write while full must be dropped.
    applyStimulus(1'b1, 1'b0, 12'hFFF);
    checkFlags("overflow", 1'b0, 1'b1, 1'b1, 1'b0);

    // Drain in order; count is 8-k after read k.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput($sformatf("drain%0d.dout", k), {20'd0, dout}, 32'(k));
      checkFlags($sformatf("drain%0d", k), (k == 8), 1'b0, ((8 - k) >= 6), ((8 - k) <= 2));
    end

    // Read while empty holds the last word.
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("underflow.dout", {20'd0, dout}, 32'h008);
    checkFlags("underflow", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 12'h0AB);
    checkFlags("after_ab_write", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("ab_read.dout", {20'd0, dout}, 32'h0AB);
    checkFlags("ab_read", 1'b1, 1'b0, 1'b0, 1'b1);

    // Preload 4 words, then 20 cycles of simultaneous read and write
    // spanning several pointer wraps.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, DW'(12'h100 + k));
    end
    checkFlags("preload4", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, DW'(12'h104 + i));
      checkOutput($sformatf("simul%0d.dout", i), {20'd0, dout}, 32'(12'h100 + i));
      checkFlags($sformatf("simul%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Fifth word, then reset mid-operation.
    applyStimulus(1'b1, 1'b0, 12'h118);
    checkFlags("count5", 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkFlags("midrst", 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst.dout", {20'd0, dout}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("postrst_read1.dout", {20'd0, dout}, 32'h0);
    checkFlags("postrst_read1", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("postrst_read2.dout", {20'd0, dout}, 32'h0);

    // Old contents are gone: the next word written is the next one read.
    applyStimulus(1'b1, 1'b0, 12'h055);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("postrst_new.dout", {20'd0, dout}, 32'h055);
    checkFlags("postrst_new", 1'b1, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
